// File: rtl/kogge_stone_sub_8bit_pipe_pkg.sv
// Shared Kogge-Stone constants: default width, prefix-depth macro, stage indices.
// No logic of its own.
// Used by both the adder and the subtractor datapaths.
`ifndef KS_LEVELS
`define KS_LEVELS(w) $clog2(w)
`endif

package kogge_stone_sub_8bit_pipe_pkg;
  localparam int KS_WIDTH_DEFAULT = 8;

  // Pipeline stage indices: capture + P/G, low prefix levels, high prefix levels + sum.
  localparam int S1 = 1;
  localparam int S2 = 2;
  localparam int S3 = 3;

  // Last prefix level evaluated in S2; S3 picks up from the next level.
  localparam int KS_S2_LAST_LEVEL = 2;
endpackage

// File: rtl/kogge_stone_sub_8bit_pipe_ks_prefix_cell.sv
// Kogge-Stone prefix operator: merge a high group (g,p) with the adjacent low group.
// Latency: combinational.
// Backpressure: none (pure logic).
module ks_prefix_cell (
  input  logic i_g_hi,
  input  logic i_p_hi,
  input  logic i_g_lo,
  input  logic i_p_lo,
  output logic o_g,
  output logic o_p
);

  assign o_g = i_g_hi | (i_p_hi & i_g_lo);
  assign o_p = i_p_hi & i_p_lo;

endmodule

// File: rtl/kogge_stone_sub_8bit_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a + ~b + 1, borrow = ~carry_out; KS_SUB_OVERFLOW_EN adds out_ovf.
// Latency: three register stages (capture/PG, prefix levels 1..2, remaining levels + sum).
// Backpressure: each stage loads when empty or draining; out_ready ripples combinationally to in_ready.
`ifndef KS_LEVELS
`define KS_LEVELS(w) $clog2(w)
`endif

module kogge_stone_sub_8bit_pipe
  import kogge_stone_sub_8bit_pipe_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
`ifdef KS_SUB_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LEVELS = `KS_LEVELS(WIDTH);

  // ---------------------------------------------------------------------------
  // Handshake: a stage advances when it is empty or its successor takes its data.
  // ---------------------------------------------------------------------------
  logic r_v1, r_v2, r_v3;
  logic w_adv1, w_adv2, w_adv3;

  assign w_adv3   = ~r_v3 | out_ready;
  assign w_adv2   = ~r_v2 | w_adv3;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign in_ready = w_adv1;

  // ---------------------------------------------------------------------------
  // S1: per-bit propagate/generate on (a, ~b). The constant carry-in of 1 is
  // folded into bit 0's generate, so every prefix g[i] already includes it.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_binv, w_p0, w_g0, w_g0c;

  assign w_binv = ~in_b;
  assign w_p0   = in_a ^ w_binv;
  assign w_g0   = in_a & w_binv;
  assign w_g0c  = {w_g0[WIDTH-1:1], w_g0[0] | w_p0[0]};

  logic [WIDTH-1:0] r_p1, r_g1;
`ifdef KS_SUB_OVERFLOW_EN
  logic r_am1, r_bm1;
`endif

  // Stage 1 register: capture operand P/G only on an input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_p1 <= '0;
      r_g1 <= '0;
`ifdef KS_SUB_OVERFLOW_EN
      r_am1 <= 1'b0;
      r_bm1 <= 1'b0;
`endif
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_p1 <= w_p0;
        r_g1 <= w_g0c;
`ifdef KS_SUB_OVERFLOW_EN
        r_am1 <= in_a[WIDTH-1];
        r_bm1 <= in_b[WIDTH-1];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2 combinational: prefix levels 1..KS_S2_LAST_LEVEL (spans 1 and 2).
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_ga [0:KS_S2_LAST_LEVEL];
  logic [WIDTH-1:0] w_pa [0:KS_S2_LAST_LEVEL];

  assign w_ga[0] = r_g1;
  assign w_pa[0] = r_p1;

  for (genvar l = 1; l <= KS_S2_LAST_LEVEL; l++) begin : g_lvl_s2
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << (l - 1))) begin : g_cell
        ks_prefix_cell u_cell (
          .i_g_hi (w_ga[l-1][i]),
          .i_p_hi (w_pa[l-1][i]),
          .i_g_lo (w_ga[l-1][i-(1<<(l-1))]),
          .i_p_lo (w_pa[l-1][i-(1<<(l-1))]),
          .o_g    (w_ga[l][i]),
          .o_p    (w_pa[l][i])
        );
      end else begin : g_pass
        assign w_ga[l][i] = w_ga[l-1][i];
        assign w_pa[l][i] = w_pa[l-1][i];
      end
    end
  end

  logic [WIDTH-1:0] r_g2, r_p2, r_x2;
`ifdef KS_SUB_OVERFLOW_EN
  logic r_am2, r_bm2;
`endif

  // Stage 2 register: partial prefix plus the raw per-bit propagate for the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_g2 <= '0;
      r_p2 <= '0;
      r_x2 <= '0;
`ifdef KS_SUB_OVERFLOW_EN
      r_am2 <= 1'b0;
      r_bm2 <= 1'b0;
`endif
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_g2 <= w_ga[KS_S2_LAST_LEVEL];
        r_p2 <= w_pa[KS_S2_LAST_LEVEL];
        r_x2 <= r_p1;
`ifdef KS_SUB_OVERFLOW_EN
        r_am2 <= r_am1;
        r_bm2 <= r_bm1;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3 combinational: remaining prefix levels (none when WIDTH=4), then sum.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_gb [KS_S2_LAST_LEVEL:LEVELS];
  logic [WIDTH-1:0] w_pb [KS_S2_LAST_LEVEL:LEVELS];

  assign w_gb[KS_S2_LAST_LEVEL] = r_g2;
  assign w_pb[KS_S2_LAST_LEVEL] = r_p2;

  for (genvar l = KS_S2_LAST_LEVEL + 1; l <= LEVELS; l++) begin : g_lvl_s3
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << (l - 1))) begin : g_cell
        ks_prefix_cell u_cell (
          .i_g_hi (w_gb[l-1][i]),
          .i_p_hi (w_pb[l-1][i]),
          .i_g_lo (w_gb[l-1][i-(1<<(l-1))]),
          .i_p_lo (w_pb[l-1][i-(1<<(l-1))]),
          .o_g    (w_gb[l][i]),
          .o_p    (w_pb[l][i])
        );
      end else begin : g_pass
        assign w_gb[l][i] = w_gb[l-1][i];
        assign w_pb[l][i] = w_pb[l-1][i];
      end
    end
  end

  // Final group propagates are not needed: only generates form carries.
  logic w_unused_p;
  assign w_unused_p = ^w_pb[LEVELS];

  // Carry into bit i is the group generate of bits i-1..0 (with carry-in); bit 0 sees the carry-in itself.
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH:0]   w_sum;

  assign w_carry = {w_gb[LEVELS][WIDTH-2:0], 1'b1};
  assign w_sum   = {w_gb[LEVELS][WIDTH-1], r_x2 ^ w_carry};

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
`ifdef KS_SUB_OVERFLOW_EN
  logic             r_ovf;
`endif

  // Stage 3 register: result held stable until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef KS_SUB_OVERFLOW_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_diff   <= w_sum[WIDTH-1:0];
        r_borrow <= ~w_sum[WIDTH];
`ifdef KS_SUB_OVERFLOW_EN
        r_ovf    <= (r_am2 ^ r_bm2) & (w_sum[WIDTH-1] ^ r_am2);
`endif
      end
    end
  end

  assign out_valid  = r_v3;
  assign out_diff   = r_diff;
  assign out_borrow = r_borrow;
`ifdef KS_SUB_OVERFLOW_EN
  assign out_ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_kogge_stone_sub_8bit_pipe.sv
// Bench for kogge_stone_sub_8bit_pipe: directed steps then a random stream against an a-b scoreboard.
// Inputs are driven 1ns after the rising edge; outputs and handshakes are sampled on the falling edge.
// Define KS_SUB_OVERFLOW_EN for both DUT and bench to exercise out_ovf.
module tb_kogge_stone_sub_8bit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_diff;
  logic       out_borrow;
`ifdef KS_SUB_OVERFLOW_EN
  logic       out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       o;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  kogge_stone_sub_8bit_pipe #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow)
`ifdef KS_SUB_OVERFLOW_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  // Reference: plain integer subtraction, unsigned for diff/borrow, signed for overflow.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int   ud;
    int   sd;
    ud  = int'(a) - int'(b);
    sd  = int'($signed(a)) - int'($signed(b));
    r.d = 8'(ud);
    r.b = (ud < 0);
    r.o = (sd < -128) || (sd > 127);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard and stability monitor.
  logic       hold = 1'b0;
  logic [7:0] hold_d;
  logic       hold_b;
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_diff", 32'(out_diff), 32'(hold_d));
        chk("hold_borrow", 32'(out_borrow), 32'(hold_b));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_diff", 32'(out_diff), 32'(e.d));
          chk("sb_borrow", 32'(out_borrow), 32'(e.b));
`ifdef KS_SUB_OVERFLOW_EN
          chk("sb_ovf", 32'(out_ovf), 32'(e.o));
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b));
      hold   = out_valid && !out_ready;
      hold_d = out_diff;
      hold_b = out_borrow;
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Present a pair (caller is at the drive point) and hold it until it transfers.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    in_valid = 1'b0;
    if (!rdy) chk("send_timeout", 32'(rdy), 1);
  endtask

  // Wait for the next output transfer and compare it with directed constants.
  task automatic expect_out(input string tag, input res_t e, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(out_valid && out_ready) && waited < 50);
    chk({tag, "_vld"}, 32'(out_valid), 1);
    chk({tag, "_diff"}, 32'(out_diff), 32'(e.d));
    chk({tag, "_borrow"}, 32'(out_borrow), 32'(e.b));
`ifdef KS_SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(e.o));
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      to_drive();
      n++;
    end
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    chk({tag, "_out_idle"}, 32'(out_valid), 0);
  endtask

  initial begin
    #5_000_000;
    $error("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   idx;
    int   sent;
    logic pend;

    // Reset held for three edges.
    repeat (3) to_drive();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_diff", 32'(out_diff), 0);
    chk("rst_out_borrow", 32'(out_borrow), 0);
`ifdef KS_SUB_OVERFLOW_EN
    chk("rst_out_ovf", 32'(out_ovf), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    to_drive();

    // Latency: result appears after the third edge counting the capture edge.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 8'h05;
    in_b = 8'h03;
    @(negedge clk);
    chk("lat_accept", 32'(in_ready), 1);
    to_drive();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1_vld", 32'(out_valid), 0);
    to_drive();
    @(negedge clk);
    chk("lat_edge2_vld", 32'(out_valid), 0);
    to_drive();
    @(negedge clk);
    chk("lat_edge3_vld", 32'(out_valid), 1);
    chk("lat_diff", 32'(out_diff), 32'h02);
    chk("lat_borrow", 32'(out_borrow), 0);
    to_drive();

    // Underflow wrap and zero case.
    send(8'h03, 8'h05);
    expect_out("under", '{8'hFE, 1'b1, 1'b0}, w);
    to_drive();
    send(8'h00, 8'h00);
    expect_out("zero", '{8'h00, 1'b0, 1'b0}, w);
    to_drive();

    // Back-to-back stream: results on consecutive cycles.
    fork
      begin
        send(8'h80, 8'h01);
        send(8'h7F, 8'hFF);
        send(8'hFF, 8'hFF);
      end
      begin
        expect_out("b2b0", '{8'h7F, 1'b0, 1'b1}, w);
        expect_out("b2b1", '{8'h80, 1'b1, 1'b1}, w);
        chk("b2b1_consecutive", 32'(w), 1);
        expect_out("b2b2", '{8'h00, 1'b0, 1'b0}, w);
        chk("b2b2_consecutive", 32'(w), 1);
      end
    join
    to_drive();

    // Stall: consumer blocked for 6 cycles while the producer keeps offering pairs.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_a = 8'h10 + 8'(idx * 7);
      in_b = 8'h30 - 8'(idx * 5);
      @(negedge clk);
      if (in_ready) idx++;
      to_drive();
    end
    chk("stall_accepted", 32'(idx), 3);
    @(negedge clk);
    chk("stall_in_ready_low", 32'(in_ready), 0);
    to_drive();
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("stall");

    // Reset with two pairs in flight: they must never emerge.
    out_ready = 1'b0;
    send(8'h40, 8'h01);
    send(8'h22, 8'h11);
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    to_drive();
    out_ready = 1'b1;
    repeat (5) to_drive();
    send(8'h9C, 8'h3D);
    expect_out("after_rst", '{8'h5F, 1'b0, 1'b1}, w);
    to_drive();
    drain("after_rst");

    // Random traffic with random producer/consumer throttling.
    sent = 0;
    pend = 1'b0;
    while (sent < 10000) begin
      to_drive();
      out_ready = ($urandom_range(0, 9) < 7);
      if (!pend) begin
        if ($urandom_range(0, 9) < 7) begin
          in_valid = 1'b1;
          in_a = 8'($urandom);
          in_b = 8'($urandom);
          pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        pend = 1'b0;
      end
    end
    to_drive();
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
